// File: rtl/sort_result_serializer.sv
// ---------------------------------------------------------------------------
// sort_result_serializer
//
// Takes the packed 4-element result of the 4-input sorting network and streams
// it out one element per cycle over a valid/ready handshake. The order is
// ascending or descending and is chosen per frame. Each accepted frame is also
// checked for non-decreasing order, and a sticky fault flag is raised when a
// frame fails that check.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   frame present on in_data
//   in_ready   block can accept a frame this cycle (combinational)
//   in_data    packed frame {y4,y3,y2,y1}, y1 in the low WIDTH bits
//   in_desc    sampled with the frame: 0 = emit y1..y4, 1 = emit y4..y1
//   out_valid  out_data holds a valid element
//   out_ready  downstream accepts the element
//   out_data   current element
//   out_index  rank of the current element (0 = y1 .. 3 = y4)
//   out_last   current element is the 4th beat of the frame
//   order_err  sticky: some accepted frame was not non-decreasing
//   frame_cnt  count of fully emitted frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module sort_result_serializer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic               in_desc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_index,
    output logic               out_last,
    output logic               order_err,
    output logic [7:0]         frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state, stateNext;
    logic [1:0]       beat, beatNext;
    logic             desc, descNext;
    logic [WIDTH-1:0] elems [4];
    logic [WIDTH-1:0] elemsNext [4];
    logic [7:0]       frameCntNext;
    logic             orderErrNext;
    logic             outValidNext;
    logic [WIDTH-1:0] outDataNext;
    logic [1:0]       outIndexNext;
    logic             outLastNext;
    logic [1:0]       rank;
    logic             advance;
    logic             accept;

    // Unsigned neighbour compare; equal neighbours are legal.
    function automatic logic isNonDecreasing(input logic [4*WIDTH-1:0] f);
        logic [WIDTH-1:0] y1, y2, y3, y4;
        y1 = f[WIDTH-1:0];
        y2 = f[2*WIDTH-1:WIDTH];
        y3 = f[3*WIDTH-1:2*WIDTH];
        y4 = f[4*WIDTH-1:3*WIDTH];
        return (y2 >= y1) && (y3 >= y2) && (y4 >= y3);
    endfunction

    assign advance  = out_valid & out_ready;
    // Opening on the last beat lets a new frame load while that beat leaves,
    // so back-to-back frames stream without a bubble.
    assign in_ready = (state == IDLE) | ((state == SEND) && (beat == 2'd3) && out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        stateNext    = state;
        beatNext     = beat;
        descNext     = desc;
        elemsNext    = elems;
        frameCntNext = frame_cnt;
        orderErrNext = order_err;

        if (advance) begin
            if (beat == 2'd3) begin
                stateNext    = IDLE;
                frameCntNext = frame_cnt + 8'd1;
            end else begin
                beatNext = beat + 2'd1;
            end
        end

        // An accept overrides the return to IDLE taken on the last beat.
        if (accept) begin
            stateNext = SEND;
            beatNext  = 2'd0;
            descNext  = in_desc;
            for (int i = 0; i < 4; i++) begin
                elemsNext[i] = in_data[i*WIDTH +: WIDTH];
            end
            if (!isNonDecreasing(in_data)) begin
                orderErrNext = 1'b1;
            end
        end

        // Outputs are computed from the next state so that they can be
        // registered and still show the first beat one cycle after accept.
        rank         = descNext ? (2'd3 - beatNext) : beatNext;
        outValidNext = (stateNext == SEND);
        outDataNext  = outValidNext ? elemsNext[rank] : '0;
        outIndexNext = outValidNext ? rank : 2'd0;
        outLastNext  = outValidNext && (beatNext == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            frame_cnt <= 8'd0;
            order_err <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            state     <= stateNext;
            beat      <= beatNext;
            frame_cnt <= frameCntNext;
            order_err <= orderErrNext;
            out_valid <= outValidNext;
            out_data  <= outDataNext;
            out_index <= outIndexNext;
            out_last  <= outLastNext;
        end
    end

    // Held frame and direction are only meaningful in SEND, so they carry
    // no reset.
    always_ff @(posedge clk) begin
        desc  <= descNext;
        elems <= elemsNext;
    end

endmodule
